// File: rtl/iiitb_bc.sv
// Free-running up/down binary counter, wraps modulo 2^WIDTH.
// Synchronous active-low reset; Count is the state register itself.
module iiitb_bc #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             UpOrDown,
  output logic [WIDTH-1:0] Count
);

  // Plain modular add/sub gives the 15->0 and 0->15 wrap without extra compare logic.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      Count <= '0;
    end else if (UpOrDown) begin
      Count <= Count + WIDTH'(1);
    end else begin
      Count <= Count - WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_iiitb_bc.sv
// Self-checking bench for iiitb_bc: directed scenarios plus a long random run
// compared against an integer modulo-16 reference model.
module tb_iiitb_bc;

  localparam int WIDTH = 4;
  localparam int MODULUS = 1 << WIDTH;

  logic             Clk;
  logic             reset;
  logic             UpOrDown;
  logic [WIDTH-1:0] Count;

  int checks = 0;
  int errors = 0;
  int model  = 0;

  iiitb_bc #(.WIDTH(WIDTH)) dut (
    .Clk      (Clk),
    .reset    (reset),
    .UpOrDown (UpOrDown),
    .Count    (Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive inputs mid-cycle, let one rising edge pass, then compare 1 ns later.
  task automatic step(input logic r, input logic d, input string tag);
    @(negedge Clk);
    reset    = r;
    UpOrDown = d;
    @(posedge Clk);
    #1;
    if (!r) model = 0;
    else if (d) model = (model + 1) % MODULUS;
    else model = (model + MODULUS - 1) % MODULUS;
    chk(tag, {{(32-WIDTH){1'b0}}, Count}, model);
  endtask

  initial begin
    reset    = 1'b0;
    UpOrDown = 1'b0;

    // Reset hold with direction toggling
    for (int i = 0; i < 3; i++) step(1'b0, i[0], "reset_hold");

    // Up with wrap: 1..15, 0, 1
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, "count_up");

    // Down with wrap from reset: 15, 14, ..., 0, then 15
    step(1'b0, 1'b1, "reset_before_down");
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, "count_down");

    // Direction reversal at 5
    step(1'b0, 1'b0, "reset_before_rev");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, "rev_up");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "rev_down");

    // Reset mid-count at 9
    step(1'b0, 1'b0, "reset_before_mid");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, "mid_up");
    step(1'b0, 1'b1, "mid_reset");
    step(1'b1, 1'b1, "mid_release");

    // Long random run: 10 us at 10 ns period
    for (int i = 0; i < 1000; i++) step(1'b1, 1'($urandom_range(0, 1)), "random_run");

    // Occasional random resets mixed in
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), "random_reset_mix");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
